// File: rtl/pipe2_pkg.sv
// Shared types for the 2-stage issue controller in front of the ALU/memory
// pipeline: instruction field widths, the packed instruction record and the
// controller state encoding.
package pipe2_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned FUNC_W = 4;
  localparam int unsigned ADDR_W = 8;

  // 24-bit instruction record, field order rs1..addr from MSB to LSB.
  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pipe2_instr_fifo.sv
// Synchronous instruction FIFO with asynchronous active-high reset.
//   clk, rst      : clock, async reset (pointers and count cleared)
//   push, wdata   : write an entry; caller guarantees !full
//   pop           : drop the head entry; caller guarantees !empty
//   rdata         : current head entry (valid while !empty)
//   empty, full   : occupancy flags
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module pipe2_instr_fifo
  import pipe2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  instr_t wdata,
  input  logic   pop,
  output instr_t rdata,
  output logic   empty,
  output logic   full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  instr_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/pipe2_issue_ctrl.sv
// Instruction issue controller for the 4-stage ALU/memory pipeline.
// Buffers instructions in a FIFO, issues at most one per cycle and holds back
// any instruction whose rs1/rs2 matches a destination issued within the last
// HAZ_WIN cycles, so the datapath needs no forwarding.
//   clk, rst                 : clock, async active-high reset
//   in_valid/in_ready, in_*  : instruction input handshake and fields
//   flush                    : request drain (no new pushes, finish queued work)
//   issue_valid, issue_*     : registered issue to the datapath
//   busy                     : controller not IDLE
//   drain_done               : one-cycle pulse when a drain completes
//   issue_cnt, stall_cnt     : wrapping statistics counters
module pipe2_issue_ctrl
  import pipe2_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned HAZ_WIN = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              flush,
  output logic              issue_valid,
  output logic [REG_W-1:0]  issue_rs1,
  output logic [REG_W-1:0]  issue_rs2,
  output logic [REG_W-1:0]  issue_rd,
  output logic [FUNC_W-1:0] issue_func,
  output logic [ADDR_W-1:0] issue_addr,
  output logic              busy,
  output logic              drain_done,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
  } sb_t;

  sb_t    sb [HAZ_WIN];
  state_t state;
  instr_t in_instr;
  instr_t head;
  logic   empty;
  logic   full;
  logic   push;
  logic   fire;
  logic   hazard;
  logic   sb_clear;

  assign in_instr = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};

  // Gated by rst so nothing is accepted during reset, and by flush so a held
  // flush cannot sneak a push in through the IDLE cycles between drains.
  assign in_ready = !rst && !full && (state != DRAIN) && !flush;
  assign push     = in_valid && in_ready;

  pipe2_instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_instr),
    .pop   (fire),
    .rdata (head),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    hazard   = 1'b0;
    sb_clear = 1'b1;
    for (int unsigned i = 0; i < HAZ_WIN; i++) begin
      if (sb[i].v) begin
        sb_clear = 1'b0;
        if ((sb[i].rd == head.rs1) || (sb[i].rd == head.rs2)) hazard = 1'b1;
      end
    end
  end

  assign fire = !empty && !hazard && (state != IDLE);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < HAZ_WIN; i++) sb[i] <= '0;
      state       <= IDLE;
      issue_valid <= 1'b0;
      issue_rs1   <= '0;
      issue_rs2   <= '0;
      issue_rd    <= '0;
      issue_func  <= '0;
      issue_addr  <= '0;
      drain_done  <= 1'b0;
      issue_cnt   <= '0;
      stall_cnt   <= '0;
    end else begin
      sb[0] <= fire ? '{v: 1'b1, rd: head.rd} : '0;
      for (int unsigned i = 1; i < HAZ_WIN; i++) sb[i] <= sb[i-1];

      issue_valid <= fire;
      drain_done  <= 1'b0;
      if (fire) begin
        issue_rs1  <= head.rs1;
        issue_rs2  <= head.rs2;
        issue_rd   <= head.rd;
        issue_func <= head.func;
        issue_addr <= head.addr;
        issue_cnt  <= issue_cnt + CNT_W'(1);
      end
      if (!empty && hazard) stall_cnt <= stall_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (flush)     state <= DRAIN;
          else if (push) state <= RUN;
        end
        RUN: begin
          if (flush)                            state <= DRAIN;
          else if (empty && !push && sb_clear) state <= IDLE;
        end
        DRAIN: begin
          if (empty && sb_clear) begin
            drain_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe2_issue_ctrl.sv
module tb_pipe2_issue_ctrl;
  import pipe2_pkg::*;

  localparam int unsigned CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_rs1, in_rs2, in_rd;
  logic [FUNC_W-1:0] in_func;
  logic [ADDR_W-1:0] in_addr;
  logic              flush;
  logic              issue_valid;
  logic [REG_W-1:0]  issue_rs1, issue_rs2, issue_rd;
  logic [FUNC_W-1:0] issue_func;
  logic [ADDR_W-1:0] issue_addr;
  logic              busy;
  logic              drain_done;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     stall_cnt;

  pipe2_issue_ctrl #(
    .DEPTH   (4),
    .HAZ_WIN (2),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .in_func     (in_func),
    .in_addr     (in_addr),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .issue_func  (issue_func),
    .issue_addr  (issue_addr),
    .busy        (busy),
    .drain_done  (drain_done),
    .issue_cnt   (issue_cnt),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;
  instr_t      exp_q[$];
  int          issue_cyc_q[$];
  int          n_pushed = 0;
  int          n_issued = 0;
  int          last_push_cyc = 0;
  bit          watch_full = 0;
  bit          saw_full = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) @cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic instr_t mk(input int rs1, input int rs2, input int rd,
                                input int func, input int addr);
    mk = '{rs1: REG_W'(rs1), rs2: REG_W'(rs2), rd: REG_W'(rd),
           func: FUNC_W'(func), addr: ADDR_W'(addr)};
  endfunction

  // Issue monitor: every issue must match the oldest pushed instruction.
  always @(negedge clk) begin
    instr_t got;
    instr_t e;
    if (!rst && issue_valid) begin
      n_issued++;
      issue_cyc_q.push_back(cyc);
      got = {issue_rs1, issue_rs2, issue_rd, issue_func, issue_addr};
      if (exp_q.size() == 0) begin
        chk("spurious_issue", 32'(issue_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("issue_fields", 32'(got), 32'(e));
      end
    end
  end

  task automatic push(input instr_t x);
    int t = 0;
    @(negedge clk);
    {in_rs1, in_rs2, in_rd, in_func, in_addr} = x;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      if (watch_full && !saw_full) begin
        #1;
        saw_full = 1;
        chk("fill_at_backpressure", 32'(n_pushed - n_issued), 32'd4);
      end
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("push_accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_pushed++;
    last_push_cyc = cyc;
  endtask

  task automatic wait_empty();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("all_issued", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    issue_cyc_q.delete();
    n_pushed = 0;
    n_issued = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int pulses;
    int done_cyc;
    bit prev_busy;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_func = '0; in_addr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Independent stream: consecutive issue one edge after each push
    push(mk(3, 5, 10, 0, 125));
    p0 = last_push_cyc;
    push(mk(4, 6, 11, 1, 126));
    push(mk(5, 7, 12, 2, 127));
    wait_empty();
    chk("indep_n", 32'(issue_cyc_q.size()), 32'd3);
    if (issue_cyc_q.size() == 3) begin
      chk("indep_lat0", 32'(issue_cyc_q[0]), 32'(p0 + 1));
      chk("indep_lat1", 32'(issue_cyc_q[1]), 32'(p0 + 2));
      chk("indep_lat2", 32'(issue_cyc_q[2]), 32'(p0 + 3));
    end
    chk("indep_issue_cnt", 32'(issue_cnt), 32'd3);
    chk("indep_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("indep_idle", 32'(busy), 32'd0);

    // RAW on rs1, then on rs2
    for (int k = 0; k < 2; k++) begin
      do_reset();
      push(mk(3, 5, 10, 0, 125));
      if (k == 0) push(mk(10, 6, 11, 1, 126));
      else        push(mk(6, 10, 11, 1, 126));
      wait_empty();
      if (issue_cyc_q.size() == 2)
        chk("raw_gap", 32'(issue_cyc_q[1] - issue_cyc_q[0]), 32'd3);
      else
        chk("raw_n", 32'(issue_cyc_q.size()), 32'd2);
      chk("raw_stall_cnt", 32'(stall_cnt), 32'd2);
      chk("raw_issue_cnt", 32'(issue_cnt), 32'd2);
    end

    // Full FIFO under a dependency chain
    do_reset();
    watch_full = 1; saw_full = 0;
    for (int i = 0; i < 8; i++) push(mk(i, 15, i + 1, i, 16 + i));
    watch_full = 0;
    wait_empty();
    chk("full_seen", 32'(saw_full), 32'd1);
    chk("full_n_issued", 32'(n_issued), 32'd8);
    chk("full_issue_cnt", 32'(issue_cnt), 32'd8);

    // Drain with 3 dependent entries queued
    do_reset();
    push(mk(0, 15, 1, 0, 1));
    push(mk(1, 15, 2, 1, 2));
    push(mk(2, 15, 3, 2, 3));
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    pulses = 0; done_cyc = 0; prev_busy = busy;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (drain_done) begin
        pulses++;
        if (pulses == 1) begin
          done_cyc = cyc;
          chk("drain_left", 32'(exp_q.size()), 32'd0);
          chk("drain_busy_fall", 32'(busy), 32'd0);
          chk("drain_busy_before", 32'(prev_busy), 32'd1);
        end
      end
      prev_busy = busy;
    end
    chk("drain_pulses", 32'(pulses), 32'd1);
    if (issue_cyc_q.size() == 3)
      chk("drain_after_sb", 32'(done_cyc - issue_cyc_q[2]), 32'd3);
    else
      chk("drain_n", 32'(issue_cyc_q.size()), 32'd3);

    // Flush from IDLE: one DRAIN cycle then a pulse
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_busy", 32'(busy), 32'd1);
    chk("idle_flush_nodone", 32'(drain_done), 32'd0);
    @(negedge clk);
    chk("idle_flush_done", 32'(drain_done), 32'd1);
    chk("idle_flush_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("idle_flush_pulse_end", 32'(drain_done), 32'd0);

    // Flush held high blocks input
    flush = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("flush_held_in_ready", 32'(in_ready), 32'd0);
    end
    flush = 1'b0;
    repeat (3) @(negedge clk);

    // Async reset mid-run
    do_reset();
    push(mk(0, 15, 1, 0, 1));
    push(mk(1, 15, 2, 1, 2));
    push(mk(2, 15, 3, 2, 3));
    @(negedge clk);
    #2;
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk("arst_issue_valid", 32'(issue_valid), 32'd0);
    chk("arst_issue_rd", 32'(issue_rd), 32'd0);
    chk("arst_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_release_ready", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("arst_no_stale", 32'(issue_cnt), 32'd0);
    chk("arst_idle", 32'(busy), 32'd0);

    // Counter wrap with 4-bit counters
    do_reset();
    for (int i = 0; i < 17; i++) push(mk(0, 0, (i % 7) + 1, i % 16, i));
    wait_empty();
    chk("wrap_n_issued", 32'(n_issued), 32'd17);
    chk("wrap_issue_cnt", 32'(issue_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
